conv_pe_lb: RTL and testbench

//  Parametrised KxK convolution PE with line buffers. Successor to the fixed 3x3 shift-register PE.

---
 rtl/conv_pe_lb_if.sv | 29 ++
 rtl/conv_pe_lb.sv | 125 ++++++++++++
 tb/tb_conv_pe_lb.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pe_lb_if.sv
// Bus bundle for conv_pe_lb: weight load channel, pixel stream and result strobe.
// Weight and pixel beats transfer on a rising edge where valid && ready; out_valid is a one-cycle strobe with no ready.
interface conv_pe_lb_if #(
  parameter int DATA_W = 9,
  parameter int K      = 3
);
  localparam int ACC_W = 2 * DATA_W + $clog2(K * K);

  logic              w_load;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ready;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              frame_done;

  modport master (
    output w_load, w_valid, w_data, pix_valid, pix_data,
    input  w_ready, pix_ready, out_valid, out_data, frame_done
  );

  modport slave (
    input  w_load, w_valid, w_data, pix_valid, pix_data,
    output w_ready, pix_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/conv_pe_lb.sv
// KxK signed convolution PE over a raster pixel stream, using K-1 line buffers and a KxK window.
// Produces one full-precision result per unpadded window, two cycles after the pixel that completes it.
module conv_pe_lb #(
  parameter int DATA_W = 9,
  parameter int K      = 3,
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10
) (
  input  logic        clk,
  input  logic        rst,
  conv_pe_lb_if.slave bus,
  output logic [1:0]  dbg_state
);
  localparam int ACC_W  = 2 * DATA_W + $clog2(K * K);
  localparam int KK     = K * K;
  localparam int PROD_W = 2 * DATA_W;
  localparam int IDX_W  = ($clog2(KK + 1) > 4) ? $clog2(KK + 1) : 4;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         w_idx;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     reload, w_acc, pix_acc, last_w;
  logic signed [DATA_W-1:0] w_reg   [KK];
  logic signed [DATA_W-1:0] win     [K][K];
  logic        [DATA_W-1:0] lb      [K-1][IMG_W];
  logic signed [DATA_W-1:0] col_vec [K];
  logic signed [PROD_W-1:0] prod    [KK];
  logic signed [ACC_W-1:0]  sum;
  logic                     v0, v1, last0, last1;

  // A reload request at the frame boundary takes priority over a pixel offered in the same cycle.
  assign reload    = (state == RUN) && bus.w_load && (row == '0) && (col == '0);
  assign w_acc     = bus.w_valid && bus.w_ready;
  assign pix_acc   = bus.pix_valid && bus.pix_ready;
  assign last_w    = (w_idx == IDX_W'(KK - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    bus.w_ready   = 1'b0;
    bus.pix_ready = 1'b0;
    case (state)
      IDLE: if (bus.w_load) state_nxt = LOAD;
      LOAD: begin
        bus.w_ready = 1'b1;
        if (w_acc && last_w) state_nxt = RUN;
      end
      RUN: begin
        bus.pix_ready = !reload;
        if (reload) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      w_idx          <= '0;
      col            <= '0;
      row            <= '0;
      v0             <= 1'b0;
      v1             <= 1'b0;
      last0          <= 1'b0;
      last1          <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.frame_done <= 1'b0;
      for (int i = 0; i < KK; i++) w_reg[i] <= '0;
    end else begin
      state <= state_nxt;
      if (reload) begin
        w_idx <= '0;
      end else if (w_acc) begin
        w_idx <= last_w ? '0 : w_idx + IDX_W'(1);
        // Weights shift in from the top so the first one loaded ends up in w_reg[0].
        for (int i = 0; i < KK - 1; i++) w_reg[i] <= w_reg[i+1];
        w_reg[KK-1] <= $signed(bus.w_data);
      end
      if (pix_acc) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      v0             <= pix_acc && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
      last0          <= pix_acc && (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
      v1             <= v0;
      last1          <= last0;
      bus.out_valid  <= v1;
      bus.frame_done <= last1;
      bus.out_data   <= sum;
    end
  end

  // Column entering the window: oldest row on top, the incoming pixel at the bottom.
  always_comb begin
    col_vec[K-1] = $signed(bus.pix_data);
    for (int i = 0; i < K - 1; i++) col_vec[i] = $signed(lb[K-2-i][col]);
  end

  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb[0][col] <= bus.pix_data;
      for (int j = 1; j < K - 1; j++) lb[j][col] <= lb[j-1][col];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= col_vec[i];
      end
    end
    for (int i = 0; i < KK; i++) prod[i] <= PROD_W'(w_reg[i]) * PROD_W'(win[i/K][i%K]);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < KK; i++) sum = sum + ACC_W'(prod[i]);
  end
endmodule

// File: tb/tb_conv_pe_lb.sv
// Bench for conv_pe_lb: directed frames checked against a frame-level convolution model with a timed expected queue.
module tb_conv_pe_lb;
  localparam int DATA_W = 9;
  localparam int K      = 3;
  localparam int IMG_W  = 10;
  localparam int IMG_H  = 10;
  localparam int KK     = K * K;
  localparam int ACC_W  = 2 * DATA_W + $clog2(K * K);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  conv_pe_lb_if #(.DATA_W(DATA_W), .K(K)) bus ();

  conv_pe_lb #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [ACC_W-1:0] exp_q[$];
  int               due_q[$];
  bit               fd_q[$];
  int               checks = 0;
  int               errors = 0;
  int               n_out, n_fd;
  longint           first_out, last_out;

  // model state
  int wts [KK];
  int wnew [KK];
  int img [IMG_H][IMG_W];
  int mr, mc;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] model_conv(int r, int c);
    longint s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(wts[i*K+j]) * longint'(img[r-K+1+i][c-K+1+j]);
    return ACC_W'(s);
  endfunction

  function automatic void model_accept(int v);
    img[mr][mc] = v;
    if (mr >= K - 1 && mc >= K - 1) begin
      exp_q.push_back(model_conv(mr, mc));
      due_q.push_back(cyc + 3);
      fd_q.push_back(mr == IMG_H - 1 && mc == IMG_W - 1);
    end
    if (mc == IMG_W - 1) begin
      mc = 0;
      mr = (mr == IMG_H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endfunction

  function automatic int pix_val(int mode, int r, int c);
    case (mode)
      0:       return 1;
      1:       return r * 10 + c;
      2:       return 255;
      default: return ((r * 37 + c * 11 + mode * 5) % 511) - 255;
    endcase
  endfunction

  // compare process
  always @(posedge clk) begin
    logic [ACC_W-1:0] e;
    int               d;
    bit               f;
    #2;
    if (rst) begin
      check("out_valid_in_reset", bus.out_valid, 0);
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        f = fd_q.pop_front();
        check("out_data", longint'($signed(bus.out_data)), longint'($signed(e)));
        check("frame_done", bus.frame_done, f);
        check("out_latency_cycle", cyc, d);
        n_out++;
        if (bus.frame_done) n_fd++;
        if (n_out == 1) first_out = longint'($signed(bus.out_data));
        last_out = longint'($signed(bus.out_data));
      end
    end else begin
      if (due_q.size() > 0 && due_q[0] < cyc) begin
        check("missing_out_valid_cycle", cyc, due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(fd_q.pop_front());
      end
      if (bus.frame_done) check("frame_done_without_out_valid", 1, 0);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.w_load    = 1'b0;
    end
  endtask

  task automatic load_weights();
    int t;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.w_load    = 1'b1;
    @(negedge clk);
    bus.w_load = 1'b0;
    for (int i = 0; i < KK; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DATA_W'(wnew[i]);
      #1;
      t = 0;
      while (!bus.w_ready && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (!bus.w_ready) begin
        check("w_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    bus.w_valid = 1'b0;
    for (int i = 0; i < KK; i++) wts[i] = wnew[i];
    #1;
    check("state_run_after_load", dbg_state, S_RUN);
  endtask

  task automatic send_pixel(input int v, input bit wl);
    int t = 0;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_data  = DATA_W'(v);
    bus.w_load    = wl;
    #1;
    while (!bus.pix_ready && t < 20) begin
      @(negedge clk);
      bus.w_load = 1'b0;
      #1;
      t++;
    end
    if (!bus.pix_ready) begin
      check("pix_ready_timeout", 0, 1);
      bus.pix_valid = 1'b0;
    end else begin
      model_accept(v);
    end
  endtask

  task automatic try_midframe_load();
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.w_load    = 1'b1;
    bus.w_valid   = 1'b1;
    bus.w_data    = DATA_W'(77);
    #1;
    check("w_ready_midframe", bus.w_ready, 0);
    @(negedge clk);
    bus.w_load = 1'b0;
    #1;
    check("state_after_midframe_wload", dbg_state, S_RUN);
    check("w_ready_after_midframe_wload", bus.w_ready, 0);
    bus.w_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gaps, input int stop_at,
                            input int wl_mid_at, input bit wl_last);
    int idx = 0;
    n_out = 0;
    n_fd  = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (idx == stop_at) return;
        if (idx == wl_mid_at) try_midframe_load();
        send_pixel(pix_val(mode, r, c), wl_last && (idx == NPIX - 1));
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        idx++;
      end
    end
    idle(5);
  endtask

  task automatic frame_stats(input string tag, input longint first_exp, input longint last_exp);
    check({tag, "_count"}, n_out, 64);
    check({tag, "_frame_done_count"}, n_fd, 1);
    check({tag, "_first"}, first_out, first_exp);
    check({tag, "_last"}, last_out, last_exp);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.w_load    = 1'b0;
    bus.w_valid   = 1'b0;
    exp_q.delete();
    due_q.delete();
    fd_q.delete();
    mr = 0;
    mc = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_state_idle", dbg_state, S_IDLE);
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_pix_ready", bus.pix_ready, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bus.w_load    = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    mr = 0;
    mc = 0;
    for (int i = 0; i < KK; i++) wts[i] = 0;
    apply_reset(3);

    // 1: all-ones box filter
    for (int i = 0; i < KK; i++) wnew[i] = 1;
    load_weights();
    send_frame(0, 1'b0, NPIX, -1, 1'b0);
    frame_stats("t1", 9, 9);

    // 2: identity kernel, out(r,c) = pixel(r-1,c-1)
    for (int i = 0; i < KK; i++) wnew[i] = (i == 4) ? 1 : 0;
    load_weights();
    send_frame(1, 1'b0, NPIX, -1, 1'b0);
    frame_stats("t2", 11, 88);

    // 3: signed extremes
    for (int i = 0; i < KK; i++) wnew[i] = -256;
    load_weights();
    send_frame(2, 1'b0, NPIX, -1, 1'b0);
    frame_stats("t3", -587520, -587520);

    // 4: mixed-sign weights, gapped frames 1 and 3
    wnew = '{3, -2, 5, -7, 1, 4, -1, 6, -3};
    load_weights();
    send_frame(3, 1'b1, NPIX, -1, 1'b0);
    check("t4a_count", n_out, 64);
    send_frame(4, 1'b0, NPIX, -1, 1'b0);
    check("t4b_count", n_out, 64);
    send_frame(5, 1'b1, NPIX, -1, 1'b0);
    check("t4c_count", n_out, 64);

    // 5: mid-frame and last-pixel w_load ignored; boundary reload applies to the next frame
    for (int i = 0; i < KK; i++) wnew[i] = 1;
    load_weights();
    send_frame(1, 1'b0, NPIX, 30, 1'b1);
    frame_stats("t5a", 99, 792);
    check("t5_state_after_last_wload", dbg_state, S_RUN);
    wnew = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    load_weights();
    send_frame(1, 1'b0, NPIX, -1, 1'b0);
    frame_stats("t5b", 681, 681 + 45 * 77);

    // 6: reset after 50 pixels, then reload and rerun the box filter
    for (int i = 0; i < KK; i++) wnew[i] = 1;
    send_frame(0, 1'b0, 50, -1, 1'b0);
    apply_reset(3);
    n_out = 0;
    idle(6);
    check("t6_no_out_after_reset", n_out, 0);
    load_weights();
    send_frame(0, 1'b0, NPIX, -1, 1'b0);
    frame_stats("t6", 9, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
